// File: rtl/tt_um_brs_dec.sv
// tt_um_brs_dec: bit-rebuild decoder, the inverse of the 16-bit priority encoder.
// Define BRS_DEC_SWEEP_EN to add the NUL+ACC sweep command (SWEEP state and counter).
module tt_um_brs_dec (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [7:0]  s1_q, s2_q;
  logic        hist_q;
  logic [15:0] v_q, v_d, onehot;
  logic [3:0]  idx;
  logic        nul, stb, acc, clr, pulse;
  logic        unused_ok;
  assign idx       = s2_q[3:0];
  assign nul       = s2_q[4];
  assign stb       = s2_q[5];
  assign acc       = s2_q[6];
  assign clr       = s2_q[7];
  assign onehot    = 16'd1 << idx;
  assign unused_ok = &{1'b0, uio_in};
  assign uo_out    = v_q[15:8];
  assign uio_out   = v_q[7:0];
  assign uio_oe    = 8'hFF;
`ifdef BRS_DEC_SWEEP_EN
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;
  logic [0:0] st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  // The edge history always advances, so a strobe swallowed during SWEEP never fires later.
  assign pulse = stb & ~hist_q & ena & ~clr & (st_q == IDLE);
  always_comb begin
    v_d   = v_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    if (clr) begin
      v_d   = 16'h0000;
      st_d  = IDLE;
      cnt_d = 4'd0;
    end else if (st_q == SWEEP) begin
      v_d   = v_q << 1;
      cnt_d = cnt_q - 4'd1;
      st_d  = (cnt_q == 4'd1) ? IDLE : SWEEP;
    end else if (pulse) begin
      if (!nul) v_d = acc ? (v_q | onehot) : onehot;
      else if (!acc) v_d = 16'h0000;
      else begin
        v_d   = 16'h0001;
        cnt_d = idx;
        st_d  = (idx == 4'd0) ? IDLE : SWEEP;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      cnt_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign pulse = stb & ~hist_q & ena & ~clr;
  always_comb begin
    v_d = v_q;
    if (clr) v_d = 16'h0000;
    else if (pulse && !nul) v_d = acc ? (v_q | onehot) : onehot;
    else if (pulse && !acc) v_d = 16'h0000;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 8'h00;
      s2_q   <= 8'h00;
      hist_q <= 1'b0;
      v_q    <= 16'h0000;
    end else begin
      s1_q   <= ui_in;
      s2_q   <= s1_q;
      hist_q <= s2_q[5];
      v_q    <= v_d;
    end
  end
endmodule

// File: tb/tb_tt_um_brs_dec.sv
// tb_tt_um_brs_dec: directed checks of the bit-rebuild decoder, with and without BRS_DEC_SWEEP_EN.
module tb_tt_um_brs_dec;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h5A;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [15:0] v, exp_v;
  logic [15:0] exp_sw [0:8];
  int checks = 0;
  int failures = 0;
  assign v = {uo_out, uio_out};
  always #5 clk = ~clk;
  tt_um_brs_dec dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Raise STB with the given fields and check V before and exactly at the update edge.
  task automatic cmd(input string tag, input logic [3:0] idx, input logic nul, input logic acc, input logic [15:0] exp);
    ui_in = {1'b0, acc, 1'b1, nul, idx};
    tick(2);
    chk({tag, "_pre"}, v, exp_v);
    tick(1);
    chk(tag, v, exp);
    exp_v = exp;
  endtask
  task automatic rel();
    ui_in = 8'h00;
    tick(3);
  endtask
  initial begin
    exp_v = 16'h0000;
`ifdef BRS_DEC_SWEEP_EN
    exp_sw = '{16'h0004, 16'h0004, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0010, 16'h0010};
`else
    exp_sw = '{default: 16'h0004};
`endif
    tick(2);
    chk("reset_v", v, 16'h0000);
    chk("reset_oe", {8'h00, uio_oe}, 16'h00FF);
    rst_n = 1'b1;
    tick(2);
    cmd("onehot9", 4'd9, 1'b0, 1'b0, 16'h0200); rel();
    chk("oe_run", {8'h00, uio_oe}, 16'h00FF);
    cmd("acc0", 4'd0, 1'b0, 1'b1, 16'h0201); rel();
    cmd("acc15", 4'd15, 1'b0, 1'b1, 16'h8201); rel();
    cmd("acc0_again", 4'd0, 1'b0, 1'b1, 16'h8201); rel();
    cmd("nul", 4'd7, 1'b1, 1'b0, 16'h0000); rel();
    // Long STB: IDX changes while held, so a second command would be visible.
    cmd("hold_first", 4'd6, 1'b0, 1'b0, 16'h0040);
    ui_in = 8'h27;
    tick(20);
    chk("hold_once", v, 16'h0040);
    rel();
    ui_in = 8'hA3;
    tick(2);
    chk("clr_pre", v, 16'h0040);
    tick(1);
    chk("clr_beats_stb", v, 16'h0000);
    tick(2);
    ui_in = 8'h00;
    tick(5);
    chk("clr_after", v, 16'h0000);
    exp_v = 16'h0000;
    cmd("set2", 4'd2, 1'b0, 1'b0, 16'h0004); rel();
    ena = 1'b0;
    ui_in = 8'h2B;
    tick(6);
    chk("ena_low", v, 16'h0004);
    rel();
    ena = 1'b1;
    tick(3);
    chk("ena_back", v, 16'h0004);
    // Sweep to IDX=4 with a replace-to-same strobe landing mid-sweep.
    ui_in = 8'h74;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      chk($sformatf("sweep_k%0d", k), v, exp_sw[k]);
      if (k == 1) ui_in = 8'h00;
      if (k == 2) ui_in = 8'h22;
      if (k == 6) ui_in = 8'h00;
    end
    rel();
`ifdef BRS_DEC_SWEEP_EN
    exp_v = 16'h0010;
    exp_sw = '{16'h0010, 16'h0010, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
    exp_v = 16'h0004;
    exp_sw = '{16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
    ui_in = 8'h79;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      chk($sformatf("sweep_clr_k%0d", k), v, exp_sw[k]);
      if (k == 0) ui_in = 8'h09;
      if (k == 1) ui_in = 8'h80;
      if (k == 4) ui_in = 8'h00;
    end
    exp_v = 16'h0000;
    cmd("idle_after_clr", 4'd3, 1'b0, 1'b0, 16'h0008); rel();
    // Reset in the middle of a long sweep.
    ui_in = 8'h7F;
    tick(5);
    ui_in = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("rst_async", v, 16'h0000);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk("rst_abort", v, 16'h0000);
    exp_v = 16'h0000;
    cmd("after_rst", 4'd1, 1'b0, 1'b0, 16'h0002); rel();
    // STB held high across reset release.
    rst_n = 1'b0;
    ui_in = 8'h2C;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    chk("rel_pre", v, 16'h0000);
    tick(1);
    chk("rel_cmd", v, 16'h1000);
    ui_in = 8'h2D;
    tick(6);
    chk("rel_once", v, 16'h1000);
    rel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
